id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between the decode stage and the execute stage of the vectorial ASIP.
- Captures decoded control fields and scalar/vector operands (128-bit lanes) using a valid/ready handshake, because vector ALU ops in execute can take multiple cycles.
- Holds its contents under back-pressure, inserts bubbles on flush, and forwards the writeback result into held operands so a stalled instruction never carries a stale register value.

Parameters:
- DATA_W, 128, operand and writeback data width.
- ADDR_W, 4, register/vector register address width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  taken branch/jump; kill held and incoming instruction.
- in_vf, in_wmem, in_rmem, in_wreg, in_conden  in  1 each  decode control bits.
- in_jmpf, in_rmuxsel, in_extndsel  in  2 each  decode control fields.
- in_aluins  in  3  ALU opcode.
- in_op2, in_op3  in  DATA_W  operands (scalar ops zero-extended to DATA_W).
- in_src2, in_src3, in_dest  in  ADDR_W  source/destination addresses.
- wb_wreg, wb_vf  in  1 each  writeback enable and vector flag.
- wb_dest  in  ADDR_W  writeback address.
- wb_data  in  DATA_W  writeback result.
- ex_ready  in  1  execute consumes the current output this cycle.
- out_valid  out  1  outputs hold a live instruction.
- out_vf, out_wmem, out_rmem, out_wreg, out_conden, out_jmpf, out_rmuxsel, out_extndsel, out_aluins, out_op2, out_op3, out_src2, out_src3, out_dest  out  registered copies, same widths as inputs.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, every control output=0, operands/addresses=0.
- in_ready = !out_valid | ex_ready (combinational). It does not depend on flush.
- capture = in_valid & in_ready & !flush. On capture, all fields load next edge and out_valid=1. Latency is 1 cycle.
- drain = out_valid & ex_ready & !capture. On drain: out_valid=0 and control outputs cleared to 0 (bubble). Operands and addresses keep their value.
- hold = out_valid & !ex_ready & !flush. On hold, all fields keep their value, except that forwarding still applies.
- flush has the highest priority. Next edge: out_valid=0 and control outputs=0. A simultaneous in_valid is dropped, not captured.
- Forwardable operands:
  - op2 is forwardable when extndsel[1]=0 and jmpf=2'b00.
  - op3 is forwardable when extndsel=2'b00.
- Forward match: wb_wreg=1, wb_dest equals the operand's src, and wb_vf equals the operand's rmuxsel bit (bit1 for op2, bit0 for op3).
- Forward value: vector match takes wb_data in full. Scalar match takes {zeros, wb_data[31:0]}.
- Forwarding applies on the capture cycle, using the incoming fields, and on every hold cycle, using the held fields. Both operands may match in the same cycle.
- Address 0 is not special; it is forwarded like any other address.
- Back-to-back: with out_valid=1, ex_ready=1 and in_valid=1, the new instruction replaces the old one with no bubble.
- Reset asserted mid-hold: contents are lost immediately. After release, the stage accepts on the first edge.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined, adds three output ports, each CNT_W wide:
  - perf_stall: counts cycles with out_valid & !ex_ready.
  - perf_bubble: counts cycles with !out_valid.
  - perf_flush: counts cycles with flush=1.
- All counters reset to 0, saturate at all-ones, and are cleared by an additional input perf_clr (synchronous, 1 bit).
- When the macro is undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset/first capture: hold rst=0 for 3 cycles and check all outputs 0. Release, drive in_valid=1, in_aluins=3'b101, in_op2=32'h5 zero-extended, ex_ready=1 → next cycle out_valid=1, out_aluins=3'b101, out_op2=128'h5, in_ready=1.
- Back-pressure: ex_ready=0 for 4 cycles with in_valid=1 → in_ready=0, outputs frozen on the first instruction. Raise ex_ready → second instruction appears one cycle later with no bubble.
- Forward on hold: held vector op with in_rmuxsel=2'b10, src2=4'h3, ex_ready=0. Drive wb_wreg=1, wb_vf=1, wb_dest=3, wb_data=128'hAAAA...A → next cycle out_op2=128'hAAAA...A and out_op3 unchanged. The same write with wb_vf=0 → no change.
- Flush priority: out_valid=1, ex_ready=0, flush=1, in_valid=1 → next cycle out_valid=0, out_wreg=0, out_wmem=0, and the new instruction is not loaded.
- Immediate operand not forwarded: capture with in_extndsel=2'b01, src3=4'h2, and wb_dest=2 in the same cycle → out_op3 equals in_op3 (the immediate), not wb_data.
- ID_EX_PERF_EN: 5 stall cycles, 2 flush cycles, then perf_clr pulse → perf_stall=5 and perf_flush=2 before the pulse, both 0 after it.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode -> execute pipeline register with valid/ready handshake.
// Captures decoded control fields and scalar/vector operands. Holds under
// back-pressure, inserts a bubble on flush or drain, and forwards the
// writeback result into operands on capture and on every hold cycle.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid / in_ready   decode handshake (in_ready is combinational)
//   flush                 kill held and incoming instruction
//   in_*                  decoded control fields, operands, addresses
//   wb_wreg/wb_vf/wb_dest/wb_data   writeback bus used for forwarding
//   ex_ready              execute consumes the current output
//   out_valid, out_*      registered instruction presented to execute
// Optional (macro ID_EX_PERF_EN):
//   perf_clr              synchronous clear of the counters
//   perf_stall/bubble/flush  saturating CNT_W-bit event counters
module id_ex_stage #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 4
`ifdef ID_EX_PERF_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              in_vf,
  input  logic              in_wmem,
  input  logic              in_rmem,
  input  logic              in_wreg,
  input  logic              in_conden,
  input  logic [1:0]        in_jmpf,
  input  logic [1:0]        in_rmuxsel,
  input  logic [1:0]        in_extndsel,
  input  logic [2:0]        in_aluins,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [DATA_W-1:0] in_op3,
  input  logic [ADDR_W-1:0] in_src2,
  input  logic [ADDR_W-1:0] in_src3,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              wb_wreg,
  input  logic              wb_vf,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic              out_vf,
  output logic              out_wmem,
  output logic              out_rmem,
  output logic              out_wreg,
  output logic              out_conden,
  output logic [1:0]        out_jmpf,
  output logic [1:0]        out_rmuxsel,
  output logic [1:0]        out_extndsel,
  output logic [2:0]        out_aluins,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_op3,
  output logic [ADDR_W-1:0] out_src2,
  output logic [ADDR_W-1:0] out_src3,
`ifdef ID_EX_PERF_EN
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_bubble,
  output logic [CNT_W-1:0]  perf_flush,
`endif
  output logic [ADDR_W-1:0] out_dest
);

  localparam int unsigned SCALAR_W = 32;

  typedef struct packed {
    logic       vf;
    logic       wmem;
    logic       rmem;
    logic       wreg;
    logic       conden;
    logic [1:0] jmpf;
    logic [1:0] rmuxsel;
    logic [1:0] extndsel;
    logic [2:0] aluins;
  } ctrl_t;

  ctrl_t             ctrl_q, ctrl_d, ctrl_in, ctrl_sel;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] op2_q, op2_d, op3_q, op3_d;
  logic [ADDR_W-1:0] src2_q, src2_d, src3_q, src3_d, dest_q, dest_d;
  logic [ADDR_W-1:0] src2_sel, src3_sel;
  logic [DATA_W-1:0] op2_sel, op3_sel, op2_fwd, op3_fwd, wb_val;
  logic              fwd2, fwd3;
  logic              capture, drain, hold;

  // Handshake qualifiers; flush dominates capture and hold.
  assign in_ready = !valid_q || ex_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign drain    = valid_q && ex_ready && !capture;
  assign hold     = valid_q && !ex_ready && !flush;

  // Forwarding: incoming fields on capture, held fields otherwise.
  always_comb begin
    ctrl_in = '{vf: in_vf, wmem: in_wmem, rmem: in_rmem, wreg: in_wreg,
                conden: in_conden, jmpf: in_jmpf, rmuxsel: in_rmuxsel,
                extndsel: in_extndsel, aluins: in_aluins};
    ctrl_sel = capture ? ctrl_in : ctrl_q;
    src2_sel = capture ? in_src2 : src2_q;
    src3_sel = capture ? in_src3 : src3_q;
    op2_sel  = capture ? in_op2  : op2_q;
    op3_sel  = capture ? in_op3  : op3_q;
    // Scalar results only carry the low word; the rest is zero.
    wb_val   = wb_vf ? wb_data : DATA_W'(wb_data[SCALAR_W-1:0]);
    // op2 is a register only without a jump and without extension on bit1.
    fwd2 = wb_wreg && (wb_dest == src2_sel) && (wb_vf == ctrl_sel.rmuxsel[1])
           && !ctrl_sel.extndsel[1] && (ctrl_sel.jmpf == 2'b00);
    // op3 is an immediate whenever any extension is selected.
    fwd3 = wb_wreg && (wb_dest == src3_sel) && (wb_vf == ctrl_sel.rmuxsel[0])
           && (ctrl_sel.extndsel == 2'b00);
    op2_fwd = fwd2 ? wb_val : op2_sel;
    op3_fwd = fwd3 ? wb_val : op3_sel;
  end

  // Next-state selection.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    op2_d   = op2_q;
    op3_d   = op3_q;
    src2_d  = src2_q;
    src3_d  = src3_q;
    dest_d  = dest_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (capture) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_in;
      op2_d   = op2_fwd;
      op3_d   = op3_fwd;
      src2_d  = in_src2;
      src3_d  = in_src3;
      dest_d  = in_dest;
    end else if (drain) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (hold) begin
      op2_d   = op2_fwd;
      op3_d   = op3_fwd;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      src2_q  <= '0;
      src3_q  <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      op2_q   <= op2_d;
      op3_q   <= op3_d;
      src2_q  <= src2_d;
      src3_q  <= src3_d;
      dest_q  <= dest_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_vf       = ctrl_q.vf;
  assign out_wmem     = ctrl_q.wmem;
  assign out_rmem     = ctrl_q.rmem;
  assign out_wreg     = ctrl_q.wreg;
  assign out_conden   = ctrl_q.conden;
  assign out_jmpf     = ctrl_q.jmpf;
  assign out_rmuxsel  = ctrl_q.rmuxsel;
  assign out_extndsel = ctrl_q.extndsel;
  assign out_aluins   = ctrl_q.aluins;
  assign out_op2      = op2_q;
  assign out_op3      = op3_q;
  assign out_src2     = src2_q;
  assign out_src3     = src3_q;
  assign out_dest     = dest_q;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d, flush_cnt_q, flush_cnt_d;

  // Saturating event counters with synchronous clear.
  always_comb begin
    stall_d     = stall_q;
    bubble_d    = bubble_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_d     = '0;
      bubble_d    = '0;
      flush_cnt_d = '0;
    end else begin
      if (valid_q && !ex_ready && (stall_q != '1))
        stall_d = stall_q + CNT_W'(1);
      if (!valid_q && (bubble_q != '1))
        bubble_d = bubble_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q     <= '0;
      bubble_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall  = stall_q;
  assign perf_bubble = bubble_q;
  assign perf_flush  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes the expected instruction
// for each consumed output; a negedge monitor pops and compares whenever
// execute takes an instruction (out_valid & ex_ready).
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef struct packed {
    logic              vf;
    logic              wmem;
    logic              rmem;
    logic              wreg;
    logic              conden;
    logic [1:0]        jmpf;
    logic [1:0]        rmuxsel;
    logic [1:0]        extndsel;
    logic [2:0]        aluins;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] op3;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] src3;
    logic [ADDR_W-1:0] dest;
  } instr_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, flush;
  logic in_vf, in_wmem, in_rmem, in_wreg, in_conden;
  logic [1:0] in_jmpf, in_rmuxsel, in_extndsel;
  logic [2:0] in_aluins;
  logic [DATA_W-1:0] in_op2, in_op3;
  logic [ADDR_W-1:0] in_src2, in_src3, in_dest;
  logic wb_wreg, wb_vf;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic ex_ready;
  logic out_valid;
  logic out_vf, out_wmem, out_rmem, out_wreg, out_conden;
  logic [1:0] out_jmpf, out_rmuxsel, out_extndsel;
  logic [2:0] out_aluins;
  logic [DATA_W-1:0] out_op2, out_op3;
  logic [ADDR_W-1:0] out_src2, out_src3, out_dest;
`ifdef ID_EX_PERF_EN
  logic perf_clr;
  logic [CNT_W-1:0] perf_stall, perf_bubble, perf_flush;
`endif

  int checks = 0;
  int errors = 0;
  instr_t exp_q[$];
  instr_t act;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)
`ifdef ID_EX_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .in_vf(in_vf), .in_wmem(in_wmem), .in_rmem(in_rmem), .in_wreg(in_wreg),
    .in_conden(in_conden), .in_jmpf(in_jmpf), .in_rmuxsel(in_rmuxsel),
    .in_extndsel(in_extndsel), .in_aluins(in_aluins), .in_op2(in_op2), .in_op3(in_op3),
    .in_src2(in_src2), .in_src3(in_src3), .in_dest(in_dest),
    .wb_wreg(wb_wreg), .wb_vf(wb_vf), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_ready(ex_ready), .out_valid(out_valid), .out_vf(out_vf), .out_wmem(out_wmem),
    .out_rmem(out_rmem), .out_wreg(out_wreg), .out_conden(out_conden),
    .out_jmpf(out_jmpf), .out_rmuxsel(out_rmuxsel), .out_extndsel(out_extndsel),
    .out_aluins(out_aluins), .out_op2(out_op2), .out_op3(out_op3),
    .out_src2(out_src2), .out_src3(out_src3),
`ifdef ID_EX_PERF_EN
    .perf_clr(perf_clr), .perf_stall(perf_stall), .perf_bubble(perf_bubble),
    .perf_flush(perf_flush),
`endif
    .out_dest(out_dest)
  );

  always_comb begin
    act          = '0;
    act.vf       = out_vf;
    act.wmem     = out_wmem;
    act.rmem     = out_rmem;
    act.wreg     = out_wreg;
    act.conden   = out_conden;
    act.jmpf     = out_jmpf;
    act.rmuxsel  = out_rmuxsel;
    act.extndsel = out_extndsel;
    act.aluins   = out_aluins;
    act.op2      = out_op2;
    act.op3      = out_op3;
    act.src2     = out_src2;
    act.src3     = out_src3;
    act.dest     = out_dest;
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t t);
    in_vf = t.vf; in_wmem = t.wmem; in_rmem = t.rmem; in_wreg = t.wreg;
    in_conden = t.conden; in_jmpf = t.jmpf; in_rmuxsel = t.rmuxsel;
    in_extndsel = t.extndsel; in_aluins = t.aluins; in_op2 = t.op2; in_op3 = t.op3;
    in_src2 = t.src2; in_src3 = t.src3; in_dest = t.dest;
  endtask

  task automatic set_wb(input logic we, input logic vf, input logic [ADDR_W-1:0] d,
                        input logic [DATA_W-1:0] data);
    wb_wreg = we; wb_vf = vf; wb_dest = d; wb_data = data;
  endtask

  // Monitor: compare every instruction consumed by execute.
  initial begin
    int n;
    instr_t e;
    n = 0;
    forever begin
      @(negedge clk);
      if (rst && out_valid && ex_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn%0d unexpected act=%h", n, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL txn%0d act=%h exp=%h", n, act, e);
          end
        end
        n++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    instr_t t, e;
    logic [DATA_W-1:0] va, vb, vc, scal;
    va = {32{4'hA}};
    vb = {32{4'hB}};
    vc = {32{4'hC}};
    scal = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h1234_5678};

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive('0); set_wb(1'b0, 1'b0, '0, '0);
`ifdef ID_EX_PERF_EN
    perf_clr = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    chk("rst_valid", DATA_W'(out_valid), '0);
    chk("rst_fields", DATA_W'(act != '0), '0);
    chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));

    // First capture immediately after release
    rst = 1'b1;
    t = '0; t.aluins = 3'b101; t.op2 = DATA_W'(32'h5);
    drive(t); in_valid = 1'b1; ex_ready = 1'b1; exp_q.push_back(t);
    tick();
    chk("cap_valid", DATA_W'(out_valid), DATA_W'(1));
    chk("cap_aluins", DATA_W'(out_aluins), DATA_W'(3'b101));
    chk("cap_op2", out_op2, DATA_W'(5));
    chk("cap_in_ready", DATA_W'(in_ready), DATA_W'(1));
    in_valid = 1'b0;
    tick();

    // Back-pressure then back-to-back replacement
    t = '0; t.aluins = 3'b011; t.wreg = 1'b1; t.op2 = 'h22; t.op3 = 'h33;
    t.src2 = 4'h1; t.src3 = 4'h2; t.dest = 4'h6;
    drive(t); in_valid = 1'b1; ex_ready = 1'b0; exp_q.push_back(t);
    tick();
    t = '0; t.aluins = 3'b110; t.rmem = 1'b1; t.op2 = 'h44; t.dest = 4'h9;
    drive(t); exp_q.push_back(t);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_in_ready", DATA_W'(in_ready), '0);
      chk("bp_frozen_op2", out_op2, 'h22);
    end
    ex_ready = 1'b1;
    tick();
    chk("b2b_valid", DATA_W'(out_valid), DATA_W'(1));
    chk("b2b_aluins", DATA_W'(out_aluins), DATA_W'(3'b110));
    in_valid = 1'b0;
    tick();

    // Vector forward on hold; scalar write with same address does not match
    t = '0; t.vf = 1'b1; t.rmuxsel = 2'b10; t.aluins = 3'b001; t.src2 = 4'h3;
    t.src3 = 4'h5; t.dest = 4'h3; t.op2 = {4{32'h1111_1111}}; t.op3 = {4{32'h2222_2222}};
    e = t; e.op2 = va;
    drive(t); in_valid = 1'b1; ex_ready = 1'b0; exp_q.push_back(e);
    tick();
    in_valid = 1'b0; set_wb(1'b1, 1'b1, 4'h3, va);
    tick();
    chk("hold_fwd_op2", out_op2, va);
    chk("hold_fwd_op3", out_op3, {4{32'h2222_2222}});
    set_wb(1'b1, 1'b0, 4'h3, vb);
    tick();
    chk("hold_nofwd_vf", out_op2, va);
    set_wb(1'b0, 1'b0, '0, '0); ex_ready = 1'b1;
    tick();

    // Scalar forward into both operands at address 0
    t = '0; t.aluins = 3'b010; t.op2 = 'h1; t.op3 = 'h2;
    e = t; e.op2 = 'h1234_5678; e.op3 = 'h1234_5678;
    drive(t); in_valid = 1'b1; ex_ready = 1'b0; exp_q.push_back(e);
    tick();
    in_valid = 1'b0; set_wb(1'b1, 1'b0, 4'h0, scal);
    tick();
    chk("scal_fwd_op2", out_op2, 'h1234_5678);
    chk("scal_fwd_op3", out_op3, 'h1234_5678);
    set_wb(1'b0, 1'b0, '0, '0); ex_ready = 1'b1;
    tick();

    // Forward on the capture cycle from incoming fields
    t = '0; t.vf = 1'b1; t.rmuxsel = 2'b11; t.aluins = 3'b100; t.src2 = 4'h4;
    t.src3 = 4'h4; t.op2 = 'h1; t.op3 = 'h2;
    e = t; e.op2 = vc; e.op3 = vc;
    drive(t); in_valid = 1'b1; set_wb(1'b1, 1'b1, 4'h4, vc); exp_q.push_back(e);
    tick();
    in_valid = 1'b0; set_wb(1'b0, 1'b0, '0, '0);
    tick();

    // Immediate op3 and jump op2 are never forwarded
    t = '0; t.extndsel = 2'b01; t.jmpf = 2'b01; t.conden = 1'b1; t.aluins = 3'b111;
    t.src2 = 4'h2; t.src3 = 4'h2; t.op2 = 'h66; t.op3 = 'h77;
    drive(t); in_valid = 1'b1; set_wb(1'b1, 1'b0, 4'h2, 'hDEAD); exp_q.push_back(t);
    tick();
    chk("imm_op3", out_op3, 'h77);
    in_valid = 1'b0; set_wb(1'b0, 1'b0, '0, '0);
    tick();

    // Flush beats hold and simultaneous capture
    t = '0; t.wreg = 1'b1; t.wmem = 1'b1; t.aluins = 3'b011; t.op2 = 'hF0; t.dest = 4'h1;
    drive(t); in_valid = 1'b1; ex_ready = 1'b0;
    tick();
    t.op2 = 'h0F; t.aluins = 3'b001;
    drive(t); flush = 1'b1;
    tick();
    chk("flush_valid", DATA_W'(out_valid), '0);
    chk("flush_wreg", DATA_W'(out_wreg), '0);
    chk("flush_wmem", DATA_W'(out_wmem), '0);
    chk("flush_aluins", DATA_W'(out_aluins), '0);
    chk("flush_not_loaded", out_op2, 'hF0);
    chk("flush_in_ready", DATA_W'(in_ready), DATA_W'(1));
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Reset asserted mid-hold, accept on first edge after release
    t = '0; t.wreg = 1'b1; t.aluins = 3'b001; t.op2 = 'h99;
    drive(t); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", DATA_W'(out_valid), '0);
    chk("midrst_fields", DATA_W'(act != '0), '0);
    tick();
    rst = 1'b1;
    t = '0; t.aluins = 3'b110; t.op2 = 'h55;
    drive(t); in_valid = 1'b1; ex_ready = 1'b1; exp_q.push_back(t);
    tick();
    chk("postrst_valid", DATA_W'(out_valid), DATA_W'(1));
    in_valid = 1'b0;
    tick();

`ifdef ID_EX_PERF_EN
    // 5 stall edges, drain, 2 flush edges (also 2 bubbles), then clear
    perf_clr = 1'b1;
    t = '0; t.aluins = 3'b101; t.op2 = 'h3;
    drive(t); in_valid = 1'b1; ex_ready = 1'b0; exp_q.push_back(t);
    tick();
    perf_clr = 1'b0; in_valid = 1'b0;
    repeat (5) tick();
    ex_ready = 1'b1;
    tick();
    flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    chk("perf_stall", DATA_W'(perf_stall), DATA_W'(5));
    chk("perf_flush", DATA_W'(perf_flush), DATA_W'(2));
    chk("perf_bubble", DATA_W'(perf_bubble), DATA_W'(2));
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_stall_clr", DATA_W'(perf_stall), '0);
    chk("perf_flush_clr", DATA_W'(perf_flush), '0);
`endif

    repeat (2) tick();
    chk("scoreboard_empty", DATA_W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
